qsn_shift_ctrl_85b: RTL
=======================

// Module: qsn_shift_ctrl_85b
// PURPOSE
//  Control-side counterpart of the 85-bit QSN permutation network.
//  - Accepts one circulant shift factor per column from the layer schedule over a valid/ready handshake.
//  - Converts each factor into the left_sel/right_sel/merge_sel triple the QSN consumes.
//  - Paces a full layer of COL_NUM columns.
//  - Generates the valid strobe aligned to the QSN's registered output.
//  - Forward mode permutes from memory to the node units; inverse mode undoes the permutation on write-back.
// PARAMETERS
//  Z        85  circulant size; legal shift range is 0..Z-1
//  COL_NUM  20  number of columns (shift factors) per layer
//  CNT_W     5  width of the column counter; must satisfy 2**CNT_W >= COL_NUM
//  QSN_LAT   1  QSN register latency, in cycles, from select to sw_out
// PORTS
//  sys_clk       in   1        system clock, rising edge
//  rst           in   1        synchronous reset, active-high
//  start         in   1        single-cycle pulse that begins a layer
//  inv_mode      in   1        sampled at start; 1 = inverse (de-permute) shift
//  shift_in      in   7        circulant shift factor s
//  shift_valid   in   1        shift_in is valid
//  shift_ready   out  1        block can accept shift_in
//  left_sel      out  7        QSN left-network select (registered)
//  right_sel     out  7        QSN right-network select (registered)
//  merge_sel     out  84       QSN merge select; 1 = take left path (registered)
//  sel_valid     out  1        selects carry a new column this cycle
//  col_idx       out  CNT_W    column index of the current selects
//  sw_out_valid  out  1        sel_valid delayed QSN_LAT cycles; QSN output is valid
//  layer_done    out  1        1-cycle pulse, coincident with the last sw_out_valid of a layer
//  shift_err     out  1        sticky flag: a shift_in >= Z was received
// BEHAVIOUR
//  Reset:
//  - rst=1 forces IDLE and zeroes every output and counter, including shift_err.
//  - Reset takes effect mid-layer: any in-flight sw_out_valid/layer_done is cancelled.
//  FSM states: IDLE, RUN, DRAIN.
//  - IDLE: shift_ready=0. On start=1: latch inv_mode, clear the column counter, go to RUN.
//  - start is ignored in RUN and DRAIN.
//  - RUN: shift_ready=1. A column is accepted when shift_valid&shift_ready. Gaps on shift_valid are allowed.
//  - On the COL_NUM-th accept, go to DRAIN; shift_ready deasserts in the following cycle.
//  - DRAIN: shift_ready=0. Wait until the final sw_out_valid, pulse layer_done in that cycle, then return to IDLE.
//  Effective shift e:
//  - s >= Z: set shift_err and treat s as 0.
//  - Forward mode: e = s.
//  - Inverse mode: e = (Z - s) mod Z, so s=0 gives e=0.
//  Select mapping, registered in the cycle after accept:
//  - e = 0: left_sel=0, right_sel=0, merge_sel=0 (pure right-path pass-through).
//  - e = 1..84: left_sel=e, right_sel=Z-e, merge_sel[k]=1 for k < Z-e, else 0 (k=0..83).
//  Timing:
//  - Accept at cycle t: selects, sel_valid=1 and col_idx become valid at t+1; sw_out_valid at t+1+QSN_LAT.
//  - When no column is accepted, selects hold their last value and sel_valid=0.
//  - col_idx counts 0..COL_NUM-1 and does not wrap within a layer; it restarts at 0 on the next start.
//  Simultaneous events:
//  - rst overrides start and shift_valid.
//  - A start arriving in the same cycle as layer_done is ignored; the next start is accepted in IDLE.
// TESTING
//  1. Assert rst for 2 cycles -> all outputs 0, FSM in IDLE, shift_ready=0.
//  2. start, then forward shifts 0, 1 and 84 back-to-back -> three selects as follows:
//     - s=0:  sels 0/0, merge 84'h0
//     - s=1:  left=1,  right=84, merge all-ones
//     - s=84: left=84, right=1,  merge 84'h1
//     sw_out_valid follows each sel_valid by 1 cycle.
//  3. start with inv_mode=1, then s=1 -> left=84, right=1, merge 84'h1. Then s=0 -> all zero.
//  4. Run a 20-column layer with random 1-3 cycle shift_valid gaps -> exactly 20 sel_valid pulses with
//     col_idx 0..19; layer_done is coincident with the 20th sw_out_valid; shift_ready=0 afterward.
//  5. shift_in=100 -> shift_err=1 (sticky), selects equal the s=0 case. A subsequent valid shift clears
//     nothing; only rst clears shift_err.
//  6. Assert rst at column 7 of a layer -> next cycle: all outputs 0, no layer_done; a new start then
//     runs a full 20-column layer.

Source files
------------

// File: rtl/qsn_shift_ctrl_85b.sv
`default_nettype none
// ============================================================================
// Module   : qsn_shift_ctrl_85b
// Brief    : Converts per-column circulant shift factors into QSN
//            left/right/merge selects and paces one layer of columns.
// Revision : 1.0 - initial release
// ============================================================================
module qsn_shift_ctrl_85b #(
    parameter int Z       = 85,
    parameter int COL_NUM = 20,
    parameter int CNT_W   = 5,
    parameter int QSN_LAT = 1
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             start,
    input  logic             inv_mode,
    input  logic [6:0]       shift_in,
    input  logic             shift_valid,
    output logic             shift_ready,
    output logic [6:0]       left_sel,
    output logic [6:0]       right_sel,
    output logic [Z-2:0]     merge_sel,
    output logic             sel_valid,
    output logic [CNT_W-1:0] col_idx,
    output logic             sw_out_valid,
    output logic             layer_done,
    output logic             shift_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [6:0]       C_Z        = 7'(Z);
    localparam logic [CNT_W-1:0] C_LAST_COL = CNT_W'(COL_NUM - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    logic [1:0]         r_state;
    logic               r_inv;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ready;
    logic [6:0]         r_left;
    logic [6:0]         r_right;
    logic [Z-2:0]       r_merge;
    logic               r_sel_valid;
    logic               r_sel_last;
    logic [CNT_W-1:0]   r_col_idx;
    logic [QSN_LAT-1:0] r_vld_pipe;
    logic [QSN_LAT-1:0] r_last_pipe;
    logic               r_err;

    logic               w_accept;
    logic               w_last_col;
    logic               w_bad;
    logic               w_layer_end;
    logic [6:0]         w_s;
    logic [6:0]         w_e;
    logic [6:0]         w_comp;
    logic [Z-2:0]       w_merge;

    assign w_accept    = (r_state == S_RUN) && shift_valid;
    assign w_last_col  = (r_cnt == C_LAST_COL);
    assign w_bad       = (shift_in >= C_Z);
    assign w_s         = w_bad ? 7'd0 : shift_in;
    // Undoing a rotation by s is a forward rotation by Z-s; s=0 stays 0.
    assign w_e         = (r_inv && (w_s != 7'd0)) ? (C_Z - w_s) : w_s;
    assign w_comp      = (w_e == 7'd0) ? 7'd0 : (C_Z - w_e);
    assign w_layer_end = r_last_pipe[QSN_LAT-1];

    // Lanes below Z-e come from the left network, the rest from the right.
    always_comb begin
        w_merge = '0;
        for (int k = 0; k < Z - 1; k++) begin
            w_merge[k] = (k < int'(w_comp));
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_inv       <= 1'b0;
            r_cnt       <= '0;
            r_ready     <= 1'b0;
            r_left      <= '0;
            r_right     <= '0;
            r_merge     <= '0;
            r_sel_valid <= 1'b0;
            r_sel_last  <= 1'b0;
            r_col_idx   <= '0;
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
            r_err       <= 1'b0;
        end else begin
            r_sel_valid    <= w_accept;
            r_sel_last     <= w_accept && w_last_col;
            r_vld_pipe[0]  <= r_sel_valid;
            r_last_pipe[0] <= r_sel_last;
            for (int i = QSN_LAT - 1; i > 0; i--) begin
                r_vld_pipe[i]  <= r_vld_pipe[i-1];
                r_last_pipe[i] <= r_last_pipe[i-1];
            end

            if (w_accept) begin
                r_left    <= w_e;
                r_right   <= w_comp;
                r_merge   <= w_merge;
                r_col_idx <= r_cnt;
                if (w_bad) begin
                    r_err <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_inv   <= inv_mode;
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (w_last_col) begin
                            r_ready <= 1'b0;
                            r_state <= S_DRAIN;
                        end else begin
                            r_cnt <= r_cnt + C_CNT_ONE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_layer_end) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign shift_ready  = r_ready;
    assign left_sel     = r_left;
    assign right_sel    = r_right;
    assign merge_sel    = r_merge;
    assign sel_valid    = r_sel_valid;
    assign col_idx      = r_col_idx;
    assign sw_out_valid = r_vld_pipe[QSN_LAT-1];
    assign layer_done   = w_layer_end;
    assign shift_err    = r_err;

endmodule
`default_nettype wire
